fp_result_packer: RTL
=====================

// Module: fp_result_packer
// PURPOSE
//  Inverse of operand unpacking: takes an unrounded FP result (sign, signed biased exponent,
//  wide mantissa with guard/round/sticky) plus special-case tags, normalizes, rounds per RISC-V
//  frm and packs it into IEEE 754 FP_WIDTH format with NX/UF/OF flags. Shared back end for the
//  adder, multiplier, FMA, divider, sqrt and convert units. 2-stage valid/ready pipeline.
// PARAMETERS
//  FP_WIDTH   32                             packed width (32 or 64)
//  EXP_BITS   (FP_WIDTH==32)?8:11            exponent field width
//  FRAC_BITS  (FP_WIDTH==32)?23:52           fraction field width
//  W          FRAC_BITS+4                    i_mant width: int bit, FRAC_BITS, guard, round, sticky
// PORTS
//  i_clk        in   1           clock
//  i_rst        in   1           synchronous, active-high reset
//  i_valid      in   1           upstream result valid
//  o_ready      out  1           packer accepts i_* this cycle
//  i_sign       in   1           result sign
//  i_exp        in   EXP_BITS+2  signed biased exponent of i_mant[W-1]
//  i_mant       in   W           unrounded mantissa; [W-1]=integer bit, [0]=sticky
//  i_sticky     in   1           extra sticky, ORed into i_mant[0]
//  i_rm         in   3           rounding mode (RNE=0,RTZ=1,RDN=2,RUP=3,RMM=4)
//  i_is_nan     in   1           force canonical NaN (sign 0, exp all ones, frac MSB only)
//  i_is_inf     in   1           force +/-inf, no flags
//  i_is_zero    in   1           force +/-0, no flags
//  o_valid      out  1           o_result/o_flags valid
//  i_ready      in   1           downstream accepts output
//  o_result     out  FP_WIDTH    packed result
//  o_flags      out  3           {OF, UF, NX}
// BEHAVIOUR
//  - Reset: both stage valids 0 (o_valid=0); o_result/o_flags regs 0. Reset mid-flight drops
//    in-flight results; no output for them. o_ready=1 during the first cycle after reset.
//  - Handshake: transfer on valid&ready at each end. Stage k advances when empty or stage k+1
//    advances; o_ready = !s1_valid | s1_advance. Latency 2 cycles, throughput 1/cycle with
//    i_ready=1; o_result/o_flags stable while o_valid&!i_ready. Priority nan>inf>zero>finite.
//  - Stage 1 normalize: i_mant==0 & !i_sticky -> treated as zero (exact, sign kept).
//    i_exp<1: right shift by min(1-i_exp, W), shifted-out bits ORed into bit 0, exp field=0.
//    Else left shift by min(lzc(i_mant), i_exp-1); exp = i_exp - shift; exp field 0 if
//    bit W-1 still clear (subnormal). Result N[W-1:0], exp E (EXP_BITS+2 signed).
//  - Stage 2 round: lsb=N[3], g=N[2], rs=N[1]|N[0]; inexact=g|rs.
//    inc: RNE g&(rs|lsb); RTZ 0; RDN sign&inexact; RUP !sign&inexact; RMM g. rm 5-7 act as RNE.
//    M = N[W-1:3]+inc (FRAC_BITS+2 bits); carry into bit FRAC_BITS+1 -> M>>=1, E+=1;
//    subnormal carry into bit FRAC_BITS -> exp field 1 (min normal).
//  - Overflow: E >= 2^EXP_BITS-1 after rounding -> OF=NX=1; result inf for RNE/RMM,
//    RUP&!sign, RDN&sign; else max finite (exp all ones-1, frac all ones).
//  - NX = inexact | OF. UF = NX & tiny; tiny (after rounding, unbounded exponent) iff stage-1
//    exp field==0 & !(N[W-2:2] all ones & unbounded inc at bit 2 using g'=N[1], s'=N[0]).
//  - Special tags: flags all 0 (caller ORs NV/DZ itself).
// STRUCTURE
//  - fpu_pkg: rounding-mode enum (frm encoding), fp_flags_t {of,uf,nx}, canonical-NaN constants.
//  - One sub-module: fp_lzc (parameterized leading-zero counter, W wide) used in stage 1.
//  - Pipeline regs per stage: valid, sign, rm, tag bits, N, E; stage 2 regs drive outputs.
// TESTING (FP_WIDTH=32, W=27, i_ready=1 unless noted)
//  - i_exp=127, i_mant=27'h4000000, RNE -> 0x3F800000, flags 0, o_valid exactly 2 cycles later.
//  - i_exp=127, i_mant=27'h4000004 (tie): RNE -> 0x3F800000 NX; RUP -> 0x3F800001 NX;
//    i_mant=27'h400000C RNE -> 0x3F800002 NX.
//  - i_exp=255, i_mant=27'h4000000: RNE -> 0x7F800000 {OF,NX}; RTZ -> 0x7F7FFFFF {OF,NX};
//    i_exp=254, i_mant=27'h7FFFFFC RNE -> 0x7F800000 {OF,NX} (overflow via rounding carry).
//  - i_exp=0, i_mant=27'h4000000 -> 0x00400000, flags 0; i_exp=-30 same mant: RNE ->
//    0x00000000 {UF,NX}, RUP -> 0x00000001 {UF,NX}; i_exp=1, i_mant=27'h0000008 -> 0x00000001.
//  - i_is_nan=1 with i_sign=1 -> 0x7FC00000 flags 0; i_is_inf=1,i_sign=1 -> 0xFF800000;
//    i_mant=0,i_sign=1 -> 0x80000000 flags 0.
//  - Backpressure: 4 back-to-back inputs, i_ready=0 for 5 cycles: o_ready drops after 2 accepted,
//    o_result held stable; on release all 4 delivered in order, none dropped/duplicated;
//    i_rst asserted with 2 in flight -> o_valid=0 next cycle, nothing emitted.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: RISC-V rounding-mode encoding, exception flag layout,
// canonical NaN patterns and the rounding-increment rules used by the result packer.
package fpu_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef struct packed {
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    localparam logic [31:0] CNAN_32 = 32'h7FC0_0000;
    localparam logic [63:0] CNAN_64 = 64'h7FF8_0000_0000_0000;

    // Encodings 5-7 are reserved and fall back to round-to-nearest-even.
    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic lsb, input logic g, input logic s);
        logic inc;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (g | s);
            RM_RUP:  inc = ~sign & (g | s);
            RM_RMM:  inc = g;
            default: inc = g & (s | lsb);
        endcase
        return inc;
    endfunction

    function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
        logic inf;
        case (rm)
            RM_RTZ:  inf = 1'b0;
            RM_RDN:  inf = sign;
            RM_RUP:  inf = ~sign;
            default: inf = 1'b1;
        endcase
        return inf;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parameterized leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data_i,
    output logic [CW-1:0] count_o
);

    // Scan upward so the highest set bit provides the final count.
    always_comb begin
        count_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            count_o = data_i[i] ? CW'(W - 1 - i) : count_o;
        end
    end

endmodule

// File: rtl/fp_result_packer.sv
// Normalizes, rounds and packs an unrounded FP result into IEEE 754 format with
// OF/UF/NX flags; two-stage valid/ready pipeline shared by all arithmetic units.
module fp_result_packer
    import fpu_pkg::*;
#(
    parameter int FP_WIDTH  = 32,
    parameter int EXP_BITS  = (FP_WIDTH == 32) ? 8 : 11,
    parameter int FRAC_BITS = (FP_WIDTH == 32) ? 23 : 52,
    parameter int W         = FRAC_BITS + 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_sign,
    input  logic [EXP_BITS+1:0]   i_exp,
    input  logic [W-1:0]          i_mant,
    input  logic                  i_sticky,
    input  logic [2:0]            i_rm,
    input  logic                  i_is_nan,
    input  logic                  i_is_inf,
    input  logic                  i_is_zero,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [FP_WIDTH-1:0]   o_result,
    output logic [2:0]            o_flags
);

    localparam int EW = EXP_BITS + 2;
    localparam int SW = $clog2(W + 1);
    localparam logic [EW:0] W_EXT   = (EW + 1)'(W);
    localparam logic [EW:0] EXP_OVF = (EW + 1)'((1 << EXP_BITS) - 1);
    localparam logic [63:0] CNAN_SEL = (FP_WIDTH == 32) ? {32'h0000_0000, CNAN_32} : CNAN_64;
    localparam logic [FP_WIDTH-1:0] CNAN = CNAN_SEL[FP_WIDTH-1:0];

    logic              s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic [2:0]        s1_rm_q;
    logic [W-1:0]      s1_n_q;
    logic [EW-1:0]     s1_e_q;
    logic              s2_valid_q;
    logic [FP_WIDTH-1:0] s2_result_q, s2_result_d;
    fp_flags_t         s2_flags_q, s2_flags_d;

    logic              s2_ready_s;
    logic [W-1:0]      mant_s, n_d;
    logic [EW-1:0]     e_d, lsh_lim_s;
    logic [EW:0]       rsh_full_s;
    logic [SW-1:0]     rsh_s, lzc_s, lsh_s;
    logic [2*W-1:0]    rsh_wide_s;
    logic              mant_zero_s, exp_low_s;

    assign s2_ready_s  = ~s2_valid_q | i_ready;
    assign o_ready     = ~s1_valid_q | s2_ready_s;
    assign mant_s      = {i_mant[W-1:1], i_mant[0] | i_sticky};
    assign mant_zero_s = (mant_s == {W{1'b0}});
    assign exp_low_s   = i_exp[EW-1] | (i_exp == {EW{1'b0}});

    fp_lzc #(.W(W)) u_lzc (
        .data_i  (mant_s),
        .count_o (lzc_s)
    );

    // Stage 1: denormalize tiny exponents with sticky collection, otherwise left-normalize.
    always_comb begin
        rsh_full_s = {{EW{1'b0}}, 1'b1} - {i_exp[EW-1], i_exp};
        rsh_s      = (rsh_full_s >= W_EXT) ? SW'(W) : rsh_full_s[SW-1:0];
        rsh_wide_s = {mant_s, {W{1'b0}}} >> rsh_s;
        lsh_lim_s  = i_exp - {{(EW-1){1'b0}}, 1'b1};
        lsh_s      = ({{(EW-SW){1'b0}}, lzc_s} < lsh_lim_s) ? lzc_s : lsh_lim_s[SW-1:0];
        if (exp_low_s) begin
            n_d = {rsh_wide_s[2*W-1:W+1], rsh_wide_s[W] | (|rsh_wide_s[W-1:0])};
            e_d = {EW{1'b0}};
        end else begin
            n_d = mant_s << lsh_s;
            e_d = n_d[W-1] ? (i_exp - {{(EW-SW){1'b0}}, lsh_s}) : {EW{1'b0}};
        end
    end

    // Stage 1 pipeline register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_rm_q    <= 3'd0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_n_q     <= {W{1'b0}};
            s1_e_q     <= {EW{1'b0}};
        end else if (o_ready) begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_sign_q <= i_sign;
                s1_rm_q   <= i_rm;
                s1_nan_q  <= i_is_nan;
                s1_inf_q  <= i_is_inf;
                s1_zero_q <= i_is_zero | mant_zero_s;
                s1_n_q    <= n_d;
                s1_e_q    <= e_d;
            end
        end
    end

    logic                 g_s, rs_s, inexact_s, inc_s, carry_s, of_s, tiny_s, nx_s;
    logic [FRAC_BITS+1:0] m_s;
    logic [FRAC_BITS-1:0] frac_s;
    logic [EW:0]          exp_r_s;

    // Stage 2: round, detect overflow/tininess and select the packed encoding.
    always_comb begin
        g_s       = s1_n_q[2];
        rs_s      = s1_n_q[1] | s1_n_q[0];
        inexact_s = g_s | rs_s;
        inc_s     = round_inc(s1_rm_q, s1_sign_q, s1_n_q[3], g_s, rs_s);
        m_s       = {1'b0, s1_n_q[W-1:3]} + {{(FRAC_BITS+1){1'b0}}, inc_s};
        carry_s   = m_s[FRAC_BITS+1];
        frac_s    = carry_s ? m_s[FRAC_BITS:1] : m_s[FRAC_BITS-1:0];
        // A subnormal that rounds up into the hidden bit becomes the minimum normal.
        exp_r_s   = {1'b0, s1_e_q} + {{EW{1'b0}}, carry_s}
                  + {{EW{1'b0}}, (s1_e_q == {EW{1'b0}}) & m_s[FRAC_BITS]};
        of_s      = (exp_r_s >= EXP_OVF);
        tiny_s    = (s1_e_q == {EW{1'b0}})
                  & ~((&s1_n_q[W-2:2])
                      & round_inc(s1_rm_q, s1_sign_q, s1_n_q[2], s1_n_q[1], s1_n_q[0]));
        nx_s      = inexact_s | of_s;
        s2_flags_d = 3'b000;
        if (s1_nan_q) begin
            s2_result_d = CNAN;
        end else if (s1_inf_q) begin
            s2_result_d = {s1_sign_q, {EXP_BITS{1'b1}}, {FRAC_BITS{1'b0}}};
        end else if (s1_zero_q) begin
            s2_result_d = {s1_sign_q, {(FP_WIDTH-1){1'b0}}};
        end else begin
            s2_flags_d.of = of_s;
            s2_flags_d.uf = nx_s & tiny_s;
            s2_flags_d.nx = nx_s;
            if (of_s && ovf_to_inf(s1_rm_q, s1_sign_q)) begin
                s2_result_d = {s1_sign_q, {EXP_BITS{1'b1}}, {FRAC_BITS{1'b0}}};
            end else if (of_s) begin
                s2_result_d = {s1_sign_q, {(EXP_BITS-1){1'b1}}, 1'b0, {FRAC_BITS{1'b1}}};
            end else begin
                s2_result_d = {s1_sign_q, exp_r_s[EXP_BITS-1:0], frac_s};
            end
        end
    end

    // Stage 2 pipeline register; holds its contents while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= {FP_WIDTH{1'b0}};
            s2_flags_q  <= 3'b000;
        end else if (s2_ready_s) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_result_q <= s2_result_d;
                s2_flags_q  <= s2_flags_d;
            end
        end
    end

    assign o_valid  = s2_valid_q;
    assign o_result = s2_result_q;
    assign o_flags  = s2_flags_q;

endmodule
